// File: rtl/k12a_alu_sequencer.sv
// k12a_alu_sequencer: steps K12A ALU/test instructions through EXEC/WRITE/EVAL and applies conditional skips
package k12a_alu_sequencer_pkg;
   typedef enum logic {ALU_OPERAND_SEL_B = 1'b0, ALU_OPERAND_SEL_INST = 1'b1} alu_operand_sel_t;
endpackage

module k12a_alu_sequencer
   import k12a_alu_sequencer_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   inst_valid,
   input  logic [15:0]            inst_in,
   output logic                   inst_ready,
   input  logic                   alu_condition,
   output logic [15:0]            inst,
   output alu_operand_sel_t       alu_operand_sel,
   output logic                   alu_subtract,
   output logic                   alu_load_n,
   output logic                   reg_load_n,
   output logic                   skip,
   output logic [COUNT_WIDTH-1:0] retire_count
);
   typedef enum logic [1:0] {IDLE, EXEC, WRITE, EVAL} state_t;
   state_t state, state_nxt;
   logic [15:0] inst_nxt;
   logic skip_nxt;
   logic [COUNT_WIDTH-1:0] count_nxt;
   logic cur_alu, cur_test, in_op;
   // classes 4..7 share inst[15:14]=01; inst[13] splits ALU from test, inst[12] marks immediate
   assign cur_alu  = inst[15:13] == 3'b010;
   assign cur_test = inst[15:13] == 3'b011;
   assign in_op    = inst_in[15:14] == 2'b01;
   assign inst_ready      = state == IDLE;
   assign alu_load_n      = state != WRITE;
   assign reg_load_n      = state != WRITE;
   assign alu_operand_sel = ((cur_alu | cur_test) & inst[12]) ? ALU_OPERAND_SEL_INST : ALU_OPERAND_SEL_B;
   assign alu_subtract    = cur_test | (cur_alu & (inst[10:8] == 3'h5));
   always_comb begin
      state_nxt = state;
      inst_nxt  = inst;
      skip_nxt  = skip;
      count_nxt = retire_count;
      case (state)
         IDLE: if (inst_valid) begin
            if (skip) skip_nxt = 1'b0;
            else begin
               inst_nxt = inst_in;
               if (in_op) state_nxt = EXEC;
               else count_nxt = retire_count + COUNT_WIDTH'(1);
            end
         end
         EXEC: state_nxt = cur_test ? EVAL : WRITE;
         WRITE: begin
            state_nxt = IDLE;
            count_nxt = retire_count + COUNT_WIDTH'(1);
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = retire_count + COUNT_WIDTH'(1);
            skip_nxt  = alu_condition ^ inst[11];
         end
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         inst         <= '0;
         skip         <= 1'b0;
         retire_count <= '0;
      end else begin
         state        <= state_nxt;
         inst         <= inst_nxt;
         skip         <= skip_nxt;
         retire_count <= count_nxt;
      end
   end
endmodule
